// File: rtl/add_result_stage.sv
// Registered output stage for the ripple-carry adder: captures sum/carry, derives
// status flags and presents results through a two-entry skid buffer.
module add_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           new_entry;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             accept;
    logic             handoff;

    // Flags are derived once, at accept time, and travel with the entry.
    always_comb begin
        new_entry.sum   = in_sum;
        new_entry.carry = in_cout;
        new_entry.zero  = (in_sum == '0);
        new_entry.neg   = in_sum[WIDTH-1];
        new_entry.ovf   = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    end

    assign accept  = in_valid && in_ready_q;
    assign handoff = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && handoff) begin
                    main_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = FULL;
                end else if (handoff) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (handoff) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready/valid are registered copies of the next state, so in_ready never sees out_ready combinationally.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_cnt) begin
            ovf_cnt_d = '0;
        end else if (accept && new_entry.ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = main_q.sum;
    assign out_carry = main_q.carry;
    assign out_zero  = main_q.zero;
    assign out_neg   = main_q.neg;
    assign out_ovf   = main_q.ovf;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Bench for add_result_stage: directed scenarios plus randomized traffic checked
// against a queue-based FIFO model with signed-arithmetic overflow.
module tb_add_result_stage;

    localparam int W  = 16;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_sum = '0;
    logic          in_cout = 1'b0;
    logic          in_a_msb = 1'b0;
    logic          in_b_msb = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic          out_zero;
    logic          out_neg;
    logic          out_ovf;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] ovf_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int sum;
        bit carry;
        bit zero;
        bit neg;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;

    add_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_zero(out_zero),
        .out_neg(out_neg), .out_ovf(out_ovf),
        .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus and advances the model; returns #1 after the edge.
    task automatic cycle(input bit v, input int s, input bit c, input bit am, input bit bm,
                         input bit exp_ovf, input bit rdy, input bit clr);
        exp_t e;
        bit   acc, hand;
        in_valid = v; in_sum = W'(s); in_cout = c; in_a_msb = am; in_b_msb = bm;
        out_ready = rdy; clr_cnt = clr;
        e.sum = s; e.carry = c; e.zero = (s == 0); e.neg = (s >= (1 << (W - 1))); e.ovf = exp_ovf;
        hand = (q.size() > 0) && rdy;
        acc  = v && (q.size() < 2);
        @(posedge clk);
        if (hand) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (clr) m_cnt = 0;
        else if (acc && exp_ovf && m_cnt < CNT_MAX) m_cnt++;
        #1;
    endtask

    // Real two's-complement addition of operands, feeding the stage as the adder would.
    task automatic add_cycle(input int a, input int b, input bit v, input bit rdy, input bit clr);
        int sa, sb, r, u;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r  = sa + sb;
        u  = a + b;
        cycle(v, u & 16'hFFFF, u > 16'hFFFF, a >= 32768, b >= 32768,
              (r > 32767) || (r < -32768), rdy, clr);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || ovf_cnt !== '0 ||
            {out_carry, out_zero, out_neg, out_ovf} !== 4'b0000) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b sum=%h flags=%b cnt=%0d want 0 1 0000 0000 0",
                     out_valid, in_ready, out_sum, {out_carry, out_zero, out_neg, out_ovf}, ovf_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_cnt = 0;
    endtask

    task automatic test_zero_carry;
        cycle(1, 0, 1, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_carry !== 1'b1 ||
            out_zero !== 1'b1 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL zero_carry: valid=%b sum=%h c=%b z=%b o=%b want 1 0000 1 1 0",
                     out_valid, out_sum, out_carry, out_zero, out_ovf);
        end
    endtask

    task automatic test_overflow;
        add_cycle(16'h7FFF, 16'h0001, 1, 1, 0);
        total++;
        if (out_sum !== 16'h8000 || out_neg !== 1'b1 || out_ovf !== 1'b1 || ovf_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ovf_pos: sum=%h n=%b o=%b cnt=%0d want 8000 1 1 1",
                     out_sum, out_neg, out_ovf, ovf_cnt);
        end
        add_cycle(16'h8000, 16'hFFFF, 1, 1, 0);
        total++;
        if (out_sum !== 16'h7FFF || out_ovf !== 1'b1 || out_neg !== 1'b0 || ovf_cnt !== 8'd2) begin
            bad++;
            $display("FAIL ovf_neg: sum=%h n=%b o=%b cnt=%0d want 7fff 0 1 2",
                     out_sum, out_neg, out_ovf, ovf_cnt);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int seen[$];
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b1 || out_sum !== 16'h0001) begin
            bad++;
            $display("FAIL stall_first: ready=%b sum=%h want 1 0001", in_ready, out_sum);
        end
        cycle(1, 2, 0, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h0001) begin
            bad++;
            $display("FAIL stall_full: ready=%b valid=%b sum=%h want 0 1 0001", in_ready, out_valid, out_sum);
        end
        cycle(1, 3, 0, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b0 || out_sum !== 16'h0001) begin
            bad++;
            $display("FAIL stall_hold: ready=%b sum=%h want 0 0001", in_ready, out_sum);
        end
        // Release the consumer and record every handed-off value while offering 0x0003.
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) seen.push_back(int'(out_sum));
            if (seen.size() < 3 && !(seen.size() == 2 && in_ready === 1'b1 && i > 1))
                cycle(1, 3, 0, 0, 0, 0, 1, 0);
            else
                cycle(0, 0, 0, 0, 0, 0, 1, 0);
            if (i == 0) begin
                total++;
                if (in_ready !== 1'b1 || out_sum !== 16'h0002) begin
                    bad++;
                    $display("FAIL stall_release: ready=%b sum=%h want 1 0002", in_ready, out_sum);
                end
            end
        end
        total++;
        if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
            bad++;
            $display("FAIL stall_order: got %0d items %p want 1 2 3", seen.size(), seen);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_dup: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) add_cycle(16'h7FFF, 16'h0001, 1, 1, 0);
        total++;
        if (ovf_cnt !== 8'd255 || m_cnt != 255) begin
            bad++;
            $display("FAIL sat: cnt=%0d want 255", ovf_cnt);
        end
        add_cycle(16'h4000, 16'h4000, 1, 1, 0);
        total++;
        if (ovf_cnt !== 8'd255) begin
            bad++;
            $display("FAIL sat_hold: cnt=%0d want 255", ovf_cnt);
        end
        add_cycle(16'h7FFF, 16'h0001, 1, 1, 1);
        total++;
        if (ovf_cnt !== 8'd0 || out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL clr_prio: cnt=%0d ovf=%b want 0 1", ovf_cnt, out_ovf);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_full;
        cycle(1, 16'h1111, 0, 0, 0, 0, 0, 0);
        add_cycle(16'h7000, 16'h7000, 1, 0, 0);
        total++;
        if (in_ready !== 1'b0 || ovf_cnt !== 8'd1) begin
            bad++;
            $display("FAIL pre_reset_full: ready=%b cnt=%0d want 0 1", in_ready, ovf_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || ovf_cnt !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b sum=%h cnt=%0d want 0 1 0000 0",
                     out_valid, in_ready, out_sum, ovf_cnt);
        end
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 16'h0055, 0, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0055) begin
            bad++;
            $display("FAIL post_reset_one: valid=%b sum=%h want 1 0055", out_valid, out_sum);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_single: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random;
        int a, b, errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            a = int'($urandom_range(0, 65535));
            case ($urandom_range(0, 7))
                0:       b = (65536 - a) & 16'hFFFF;
                1:       b = 16'h8000 | a;
                default: b = int'($urandom_range(0, 65535));
            endcase
            add_cycle(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 63) == 0);
            total++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
                ovf_cnt !== CW'(m_cnt) ||
                (q.size() > 0 && (out_sum !== W'(q[0].sum) || out_carry !== q[0].carry ||
                                  out_zero !== q[0].zero || out_neg !== q[0].neg ||
                                  out_ovf !== q[0].ovf))) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: valid=%b ready=%b sum=%h flags=%b cnt=%0d want valid=%b ready=%b sum=%h flags=%b cnt=%0d",
                             i, out_valid, in_ready, out_sum, {out_carry, out_zero, out_neg, out_ovf}, ovf_cnt,
                             q.size() > 0, q.size() < 2, (q.size() > 0) ? q[0].sum : 0,
                             (q.size() > 0) ? {q[0].carry, q[0].zero, q[0].neg, q[0].ovf} : 4'b0, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_carry();
        test_overflow();
        test_back_to_back();
        test_saturation();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
